gf16_inv_gen: RTL and testbench
===============================

Name: gf16_inv_gen

Overview:
- GF(2^16) inversion responder for the polynomial divider datapath.
- Accepts the divisor leading coefficient on the inv_en / inv_trg / inv_in interface and returns its field inverse on inv_r_dat after a fixed latency.
- Algorithm: a^-1 = a^(2^16-2), using iterated square-and-multiply over one combinational step.
- Sits beside the multiplier array in the ALU; the divider samples inv_r_dat at least 18 cycles after asserting inv_trg.

Parameters:
- M, 16, field width.
- POLY, 16'h100B, reduction polynomial low terms: field is x^16+x^12+x^3+x+1.
- N_ITER, 14, number of r = r^2·a steps before the final squaring.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inv_en  in  1  enable; low forces IDLE and aborts any operation.
- inv_trg  in  1  one-cycle start strobe, honoured only while inv_en=1.
- inv_in  in  [0:15]  operand; bit 0 = x^15 coefficient, bit 15 = x^0 coefficient.
- inv_r_dat  out  [0:15]  inverse; same bit order; held until the next completion.
- inv_busy  out  1  high while in ITER.
- inv_done  out  1  one-cycle pulse when inv_r_dat updates.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, inv_r_dat=0, inv_busy=0, inv_done=0, base/acc/cnt=0. Reset mid-operation discards the operation.
- Internal registers: base[0:15], acc[0:15], cnt[3:0].
- Step function: sqmul(r,a) = (r·r mod P)·a mod P, combinational, polynomial basis.
- IDLE:
  - inv_done cleared every cycle it is not being set.
  - If inv_en & inv_trg are sampled at edge T: base<=inv_in, acc<=inv_in, cnt<=0, go to ITER, inv_busy<=1.
- ITER:
  - cnt 0..13 (edges T+1..T+14): acc<=sqmul(acc,base), cnt++.
  - cnt==14 (edge T+15): inv_r_dat<=acc·acc mod P, inv_done<=1, inv_busy<=0, go to IDLE.
- Latency: result visible in the cycle after edge T+15 (15 cycles). inv_done is high for exactly that cycle.
- inv_en=0 in any state: go to IDLE next edge, inv_busy<=0, no inv_done, inv_r_dat unchanged.
- inv_trg with inv_en=1 while in ITER: restart. Reload base/acc from the new inv_in, cnt<=0; the old result is never published.
- inv_trg with inv_en=0: ignored.
- Operand 0: the algorithm yields 0, so inv_r_dat=0x0000. No error flag.
- inv_r_dat does not change except on completion or reset.

Optional Feature:
- Macro: GF16_INV_FAST_EN.
- Defined:
  - Two sqmul stages are chained per cycle.
  - cnt 0..6 (edges T+1..T+7): acc<=sqmul(sqmul(acc,base),base).
  - cnt==7 (edge T+8): final squaring to inv_r_dat, inv_done pulse.
  - Latency is 8 cycles. All other rules are unchanged.
- Undefined: single-stage, 15-cycle latency as above.

Decomposition:
- Shared package gf16_pkg:
  - M, POLY.
  - typedef gf16_t = logic [0:15].
  - State enum {IDLE, ITER}.
  - N_ITER, N_ITER_FAST=7.
  - Pure functions gf16_sq and gf16_mul, shared with the multiplier array model.
- One sub-module: gf16_sqmul, combinational (r, a) -> r^2·a.
  - Instantiated once, or twice in series under GF16_INV_FAST_EN.
- The FSM and counter stay in gf16_inv_gen.

Test Plan:
- rst high 2 cycles, then inv_en=1, inv_trg pulse with inv_in=0x0001: inv_busy high for 15 cycles; inv_done pulses; inv_r_dat=0x0001 (8 cycles with the fast macro).
- inv_in=0x0002 (x): inv_r_dat=0x8805 (x^15+x^11+x^2+1); inv_done exactly 15 cycles after the trigger edge.
- inv_in=0x0000: inv_r_dat=0x0000, inv_done still pulses.
- 1000 random nonzero operands: gf16_mul(inv_in, inv_r_dat)==0x0001 each time, and inv_r_dat is stable between pulses.
- Trigger 0x0002, retrigger 0x0001 at cycle 5: only one inv_done, 15 cycles after the second trigger, with inv_r_dat=0x0001. 0x8805 never appears.
- Drop inv_en mid-ITER, or assert rst mid-ITER: no inv_done. inv_r_dat keeps its prior value (inv_en case) or becomes 0x0000 (rst case). Busy falls next cycle.

Source files
------------

// File: rtl/gf16_pkg.sv
// gf16_pkg -- shared GF(2^16) definitions for the inversion responder and the
// multiplier array model.
//   Field: x^16 + x^12 + x^3 + x + 1 (POLY holds the low terms).
//   gf16_t is declared [0:15] so bit 0 carries x^15 and bit 15 carries x^0;
//   the numeric value of a vector therefore reads directly as the polynomial.
// Ports: none (package).
package gf16_pkg;

   localparam int          M           = 16;
   localparam logic [15:0] POLY        = 16'h100B;
   localparam logic [3:0]  N_ITER      = 4'd14;
   localparam logic [3:0]  N_ITER_FAST = 4'd7;

   typedef logic [0:M-1] gf16_t;

   typedef enum logic {
      IDLE,
      ITER
   } state_t;

   // Polynomial-basis multiply, MSB-first shift-and-add with reduction on
   // every shift so the partial product never exceeds 16 bits.
   function automatic gf16_t gf16_mul(gf16_t a, gf16_t b);
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] p;
      x = a;
      y = b;
      p = '0;
      for (int i = 15; i >= 0; i--) begin
         p = {p[14:0], 1'b0} ^ (p[15] ? POLY : 16'h0000);
         if (y[i]) begin
            p = p ^ x;
         end
      end
      return gf16_t'(p);
   endfunction

   function automatic gf16_t gf16_sq(gf16_t a);
      return gf16_mul(a, a);
   endfunction

endpackage

// File: rtl/gf16_inv_gen_if.sv
// gf16_inv_gen_if -- request/response bundle between the polynomial divider
// (master) and the GF(2^16) inversion responder (slave).
//   inv_en    : enable, low aborts and idles the responder
//   inv_trg   : one-cycle start strobe
//   inv_in    : operand
//   inv_r_dat : inverse, held until the next completion
//   inv_busy  : responder is iterating
//   inv_done  : one-cycle pulse when inv_r_dat updates
interface gf16_inv_gen_if;
   import gf16_pkg::*;

   logic  inv_en;
   logic  inv_trg;
   gf16_t inv_in;
   gf16_t inv_r_dat;
   logic  inv_busy;
   logic  inv_done;

   modport master (
      output inv_en, inv_trg, inv_in,
      input  inv_r_dat, inv_busy, inv_done
   );

   modport slave (
      input  inv_en, inv_trg, inv_in,
      output inv_r_dat, inv_busy, inv_done
   );

endinterface

// File: rtl/gf16_sqmul.sv
// gf16_sqmul -- combinational exponentiation step y = r^2 * a in GF(2^16).
// Ports:
//   r : running accumulator
//   a : base operand
//   y : r*r*a reduced modulo the field polynomial
module gf16_sqmul
   import gf16_pkg::*;
(
   input  gf16_t r,
   input  gf16_t a,
   output gf16_t y
);

   assign y = gf16_mul(gf16_sq(r), a);

endmodule

// File: rtl/gf16_inv_gen.sv
// gf16_inv_gen -- GF(2^16) inversion responder computing a^(2^16-2).
// Each step maps acc -> acc^2 * a, so after k steps the exponent is
// 2^(k+1)-1; fourteen steps give 2^15-1 and one final squaring gives
// 2^16-2 = a^-1 (operand 0 maps to 0).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   inv : gf16_inv_gen_if slave modport (inv_en/inv_trg/inv_in in,
//         inv_r_dat/inv_busy/inv_done out)
// Build option: GF16_INV_FAST_EN chains two steps per cycle, so the
// iteration takes 7 cycles instead of 14 (latency 8 instead of 15).
module gf16_inv_gen
   import gf16_pkg::*;
(
   input logic          clk,
   input logic          rst,
   gf16_inv_gen_if.slave inv
);

`ifdef GF16_INV_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam logic [3:0] LAST = FAST ? N_ITER_FAST : N_ITER;

   state_t     state, state_next;
   gf16_t      base, base_next;
   gf16_t      acc, acc_next;
   logic [3:0] cnt, cnt_next;
   gf16_t      r_dat, r_dat_next;
   logic       done, done_next;
   gf16_t      step;

`ifdef GF16_INV_FAST_EN
   gf16_t mid;

   gf16_sqmul u_sqmul0 (.r(acc), .a(base), .y(mid));
   gf16_sqmul u_sqmul1 (.r(mid), .a(base), .y(step));
`else
   gf16_sqmul u_sqmul0 (.r(acc), .a(base), .y(step));
`endif

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
         acc   <= '0;
         cnt   <= '0;
         r_dat <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         base  <= base_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         r_dat <= r_dat_next;
         done  <= done_next;
      end
   end

   // Next-state logic. Disable wins over everything, a trigger restarts
   // even mid-iteration (so a pending result is never published), and the
   // terminal count performs the final squaring into the result register.
   always_comb begin
      state_next = state;
      base_next  = base;
      acc_next   = acc;
      cnt_next   = cnt;
      r_dat_next = r_dat;
      done_next  = 1'b0;

      if (!inv.inv_en) begin
         state_next = IDLE;
      end else if (inv.inv_trg) begin
         base_next  = inv.inv_in;
         acc_next   = inv.inv_in;
         cnt_next   = '0;
         state_next = ITER;
      end else if (state == ITER) begin
         if (cnt == LAST) begin
            r_dat_next = gf16_sq(acc);
            done_next  = 1'b1;
            state_next = IDLE;
         end else begin
            acc_next = step;
            cnt_next = cnt + 4'd1;
         end
      end
   end

   assign inv.inv_r_dat = r_dat;
   assign inv.inv_busy  = (state == ITER);
   assign inv.inv_done  = done;

endmodule

// File: tb/tb_gf16_inv_gen.sv
// tb_gf16_inv_gen -- directed-vector bench for gf16_inv_gen, with a
// randomised inverse-product sweep checked against an independent
// schoolbook multiplier.
module tb_gf16_inv_gen;

`ifdef GF16_INV_FAST_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 15;
`endif

   logic clk;
   logic rst;
   int   errorCount;
   int   checkCount;

   gf16_inv_gen_if bus ();

   gf16_inv_gen dut (
      .clk (clk),
      .rst (rst),
      .inv (bus)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Independent reference: full 31-bit carry-less product, then reduce
   // from the top using x^16 + x^12 + x^3 + x + 1.
   function automatic logic [15:0] tbMul(logic [15:0] a, logic [15:0] b);
      logic [30:0] p;
      logic [30:0] full;
      p    = '0;
      full = 31'h1100B;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) p = p ^ (31'(a) << i);
      end
      for (int i = 30; i >= 16; i--) begin
         if (p[i]) p = p ^ (full << (i - 16));
      end
      return p[15:0];
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One-cycle trigger pulse; returns at the falling edge after the
   // capturing rising edge.
   task automatic applyStimulus(input logic [15:0] val);
      @(negedge clk);
      bus.inv_trg = 1'b1;
      bus.inv_in  = val;
      @(negedge clk);
      bus.inv_trg = 1'b0;
   endtask

   // Trigger and follow one operation to completion, checking latency,
   // busy width, result hold before completion and done pulse width.
   task automatic runOp(input logic [15:0] val, output logic [15:0] res);
      logic [15:0] prev;
      int          lat;
      int          busyCnt;
      bit          seen;
      bit          moved;
      prev    = bus.inv_r_dat;
      applyStimulus(val);
      lat     = 0;
      busyCnt = 0;
      seen    = 1'b0;
      moved   = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         if (bus.inv_done) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            if (bus.inv_busy) busyCnt++;
            if (bus.inv_r_dat !== prev) moved = 1'b1;
            @(negedge clk);
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("latency", 32'(lat), 32'(LAT));
      checkOutput("busy_cycles", 32'(busyCnt), 32'(LAT));
      checkOutput("hold_until_done", 32'(moved), 32'd0);
      checkOutput("busy_at_done", 32'(bus.inv_busy), 32'd0);
      res = bus.inv_r_dat;
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(bus.inv_done), 32'd0);
   endtask

   // Watch n cycles: no done pulse and the result must stay at expDat.
   task automatic watchQuiet(input int n, input logic [15:0] expDat);
      int doneCnt;
      bit moved;
      doneCnt = 0;
      moved   = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (bus.inv_done) doneCnt++;
         if (bus.inv_r_dat !== expDat) moved = 1'b1;
         @(negedge clk);
      end
      checkOutput("quiet_no_done", 32'(doneCnt), 32'd0);
      checkOutput("quiet_hold", 32'(moved), 32'd0);
   endtask

   // Main directed sequence.
   initial begin
      logic [15:0] res;
      logic [15:0] val;
      errorCount  = 0;
      checkCount  = 0;
      rst         = 1'b1;
      bus.inv_en  = 1'b0;
      bus.inv_trg = 1'b0;
      bus.inv_in  = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_r_dat", 32'(bus.inv_r_dat), 32'h0000);
      checkOutput("reset_busy", 32'(bus.inv_busy), 32'd0);
      checkOutput("reset_done", 32'(bus.inv_done), 32'd0);
      rst        = 1'b0;
      bus.inv_en = 1'b1;

      runOp(16'h0001, res);
      checkOutput("inv_of_1", 32'(res), 32'h0001);
      runOp(16'h0002, res);
      checkOutput("inv_of_x", 32'(res), 32'h8805);
      runOp(16'h8805, res);
      checkOutput("inv_of_8805", 32'(res), 32'h0002);
      runOp(16'h0000, res);
      checkOutput("inv_of_0", 32'(res), 32'h0000);

      for (int n = 0; n < 1000; n++) begin
         val = 16'($urandom_range(1, 65535));
         runOp(val, res);
         checkOutput("inverse_product", 32'(tbMul(val, res)), 32'h0001);
      end

      // Restart mid-iteration: first operation must never publish.
      applyStimulus(16'h0001);
      runOp(16'h0001, res);
      checkOutput("known_before_retrig", 32'(res), 32'h0001);
      applyStimulus(16'h0002);
      repeat (3) begin
         checkOutput("no_done_before_retrig", 32'(bus.inv_done), 32'd0);
         @(negedge clk);
      end
      runOp(16'h0001, res);
      checkOutput("retrig_result", 32'(res), 32'h0001);
      watchQuiet(30, 16'h0001);

      // Enable dropped mid-iteration: result untouched.
      applyStimulus(16'h0002);
      repeat (5) @(negedge clk);
      bus.inv_en = 1'b0;
      @(negedge clk);
      checkOutput("en_abort_busy", 32'(bus.inv_busy), 32'd0);
      watchQuiet(30, 16'h0001);
      bus.inv_en = 1'b1;

      // Reset mid-iteration: result cleared, no completion.
      applyStimulus(16'h0002);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_abort_busy", 32'(bus.inv_busy), 32'd0);
      checkOutput("rst_abort_r_dat", 32'(bus.inv_r_dat), 32'h0000);
      rst = 1'b0;
      watchQuiet(30, 16'h0000);

      // Trigger while disabled is ignored.
      bus.inv_en = 1'b0;
      applyStimulus(16'h0003);
      checkOutput("trg_disabled_busy", 32'(bus.inv_busy), 32'd0);
      watchQuiet(30, 16'h0000);
      bus.inv_en = 1'b1;

      runOp(16'h0002, res);
      checkOutput("recovery_inv_of_x", 32'(res), 32'h8805);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
